// File: rtl/binary_encoder_4to2.sv
// Registered 4-to-2 MSB-priority encoder with valid and one-hot grant.
// Optional BINENC_MULTIHOT_EN adds a registered multi_hot flag.
module binary_encoder_4to2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] binary_input,
  output logic [1:0] encoded_output,
  output logic       valid_out,
  output logic [3:0] grant_onehot
`ifdef BINENC_MULTIHOT_EN
  ,
  output logic       multi_hot
`endif
);

  logic [1:0] enc_d;
  logic [3:0] grant_d;
  logic       valid_d;

  // Overlapping items are intended here: the first match wins.
  always_comb begin
    enc_d   = 2'b00;
    grant_d = 4'b0000;
    priority case (1'b1)
      binary_input[3]: begin
        enc_d   = 2'b11;
        grant_d = 4'b1000;
      end
      binary_input[2]: begin
        enc_d   = 2'b10;
        grant_d = 4'b0100;
      end
      binary_input[1]: begin
        enc_d   = 2'b01;
        grant_d = 4'b0010;
      end
      binary_input[0]: begin
        enc_d   = 2'b00;
        grant_d = 4'b0001;
      end
      default: begin
        enc_d   = 2'b00;
        grant_d = 4'b0000;
      end
    endcase
  end

  assign valid_d = |binary_input;

  always_ff @(posedge clk) begin
    if (rst) begin
      encoded_output <= 2'b00;
      valid_out      <= 1'b0;
      grant_onehot   <= 4'b0000;
    end else begin
      encoded_output <= enc_d;
      valid_out      <= valid_d;
      grant_onehot   <= grant_d;
    end
  end

`ifdef BINENC_MULTIHOT_EN
  logic mh_d;

  // Two or more bits set: some bit pairs with any lower bit.
  assign mh_d =
    (binary_input[3] & (|binary_input[2:0])) |
    (binary_input[2] & (|binary_input[1:0])) |
    (binary_input[1] & binary_input[0]);

  always_ff @(posedge clk) begin
    if (rst) multi_hot <= 1'b0;
    else     multi_hot <= mh_d;
  end
`endif

endmodule

// File: tb/tb_binary_encoder_4to2.sv
// Directed self-checking bench for binary_encoder_4to2.
// Checks multi_hot too when BINENC_MULTIHOT_EN is defined.
module tb_binary_encoder_4to2;

  logic       clk;
  logic       rst;
  logic [3:0] binary_input;
  logic [1:0] encoded_output;
  logic       valid_out;
  logic [3:0] grant_onehot;
`ifdef BINENC_MULTIHOT_EN
  logic       multi_hot;
`endif

  int passed;
  int total;

  binary_encoder_4to2 dut (
    .clk            (clk),
    .rst            (rst),
    .binary_input   (binary_input),
    .encoded_output (encoded_output),
    .valid_out      (valid_out),
    .grant_onehot   (grant_onehot)
`ifdef BINENC_MULTIHOT_EN
    ,
    .multi_hot      (multi_hot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then observe 1 time unit after the rising edge.
  task automatic cycle(input logic [3:0] v, input logic r);
    @(negedge clk);
    binary_input = v;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    for (int i = 0; i < 2; i++) begin
      cycle(4'b1111, 1'b1);
      obs = {encoded_output, valid_out, grant_onehot};
      total++;
      if (obs !== 7'b00_0_0000)
        $display("FAIL reset_hold%0d got=%b want=%b", i, obs, 7'b00_0_0000);
      else passed++;
`ifdef BINENC_MULTIHOT_EN
      total++;
      if (multi_hot !== 1'b0)
        $display("FAIL reset_mh%0d got=%b want=0", i, multi_hot);
      else passed++;
`endif
    end
    cycle(4'b1111, 1'b0);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b11_1_1000)
      $display("FAIL reset_release got=%b want=%b", obs, 7'b11_1_1000);
    else passed++;
  endtask

  task automatic test_single_bit();
    logic [3:0] vin [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] ven [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [6:0] obs;
    logic [6:0] exp;
    for (int i = 0; i < 4; i++) begin
      cycle(vin[i], 1'b0);
      obs = {encoded_output, valid_out, grant_onehot};
      exp = {ven[i], 1'b1, vin[i]};
      total++;
      if (obs !== exp)
        $display("FAIL single_%b got=%b want=%b", vin[i], obs, exp);
      else passed++;
`ifdef BINENC_MULTIHOT_EN
      total++;
      if (multi_hot !== 1'b0)
        $display("FAIL single_mh_%b got=%b want=0", vin[i], multi_hot);
      else passed++;
`endif
    end
  endtask

  task automatic test_priority();
    logic [3:0] vin [5] = '{4'b1010, 4'b0110, 4'b1100, 4'b1111, 4'b0011};
    logic [6:0] vexp [5] = '{7'b11_1_1000, 7'b10_1_0100, 7'b11_1_1000,
                             7'b11_1_1000, 7'b01_1_0010};
    logic [6:0] obs;
    for (int i = 0; i < 5; i++) begin
      cycle(vin[i], 1'b0);
      obs = {encoded_output, valid_out, grant_onehot};
      total++;
      if (obs !== vexp[i])
        $display("FAIL prio_%b got=%b want=%b", vin[i], obs, vexp[i]);
      else passed++;
`ifdef BINENC_MULTIHOT_EN
      total++;
      if (multi_hot !== 1'b1)
        $display("FAIL prio_mh_%b got=%b want=1", vin[i], multi_hot);
      else passed++;
`endif
    end
  endtask

  task automatic test_zero();
    logic [6:0] obs;
    cycle(4'b0000, 1'b0);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b00_0_0000)
      $display("FAIL zero got=%b want=%b", obs, 7'b00_0_0000);
    else passed++;
`ifdef BINENC_MULTIHOT_EN
    total++;
    if (multi_hot !== 1'b0)
      $display("FAIL zero_mh got=%b want=0", multi_hot);
    else passed++;
`endif
    cycle(4'b0001, 1'b0);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b00_1_0001)
      $display("FAIL zero_vs_0001 got=%b want=%b", obs, 7'b00_1_0001);
    else passed++;
  endtask

  task automatic test_midstream_reset();
    logic [6:0] obs;
    cycle(4'b1000, 1'b0);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b11_1_1000)
      $display("FAIL mid_pre got=%b want=%b", obs, 7'b11_1_1000);
    else passed++;
    cycle(4'b0100, 1'b1);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b00_0_0000)
      $display("FAIL mid_rst got=%b want=%b", obs, 7'b00_0_0000);
    else passed++;
    cycle(4'b0100, 1'b0);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b10_1_0100)
      $display("FAIL mid_post got=%b want=%b", obs, 7'b10_1_0100);
    else passed++;
  endtask

  task automatic test_input_glitch();
    logic [6:0] obs;
    cycle(4'b0010, 1'b0);
    binary_input = 4'b1000;
    #2;
    binary_input = 4'b0101;
    @(negedge clk);
    obs = {encoded_output, valid_out, grant_onehot};
    total++;
    if (obs !== 7'b01_1_0010)
      $display("FAIL glitch_hold got=%b want=%b", obs, 7'b01_1_0010);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] vexp [16] = '{
      7'b00_0_0000, 7'b00_1_0001, 7'b01_1_0010, 7'b01_1_0010,
      7'b10_1_0100, 7'b10_1_0100, 7'b10_1_0100, 7'b10_1_0100,
      7'b11_1_1000, 7'b11_1_1000, 7'b11_1_1000, 7'b11_1_1000,
      7'b11_1_1000, 7'b11_1_1000, 7'b11_1_1000, 7'b11_1_1000};
    logic [15:0] mh_tab = 16'b1111_1110_1110_1000;
    logic [6:0]  obs;
    for (int i = 0; i < 16; i++) begin
      cycle(4'(i), 1'b0);
      obs = {encoded_output, valid_out, grant_onehot};
      total++;
      if (obs !== vexp[i])
        $display("FAIL exh_%0d got=%b want=%b", i, obs, vexp[i]);
      else passed++;
`ifdef BINENC_MULTIHOT_EN
      total++;
      if (multi_hot !== mh_tab[i])
        $display("FAIL exh_mh_%0d got=%b want=%b", i, multi_hot, mh_tab[i]);
      else passed++;
`else
      if (mh_tab[i] === 1'bx) $display("FAIL table");
`endif
    end
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    binary_input = 4'b0000;
    test_reset();
    test_single_bit();
    test_priority();
    test_zero();
    test_midstream_reset();
    test_input_glitch();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
